// File: rtl/alu_share_arb_if.sv
// -----------------------------------------------------------------------------
// alu_share_arb_if
// Bundle of every handshake/bus signal around the shared-ALU arbiter.
//   req0_* / req1_* : two requester channels (valid/ready + opcode/shamt/a/b)
//   alu_*           : registered operands out to the ALU, result/flags back
//   rsp_*           : single tagged response channel (valid/ready + id/result/flags)
//   busy            : arbiter has a transaction in flight
// Modports:
//   slave  : the arbiter side (alu_share_arb)
//   master : the environment side (requesters, ALU and response consumer)
// -----------------------------------------------------------------------------
interface alu_share_arb_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [4:0]  req0_opcode;
    logic [4:0]  req0_shamt;
    logic [31:0] req0_a;
    logic [31:0] req0_b;

    logic        req1_valid;
    logic        req1_ready;
    logic [4:0]  req1_opcode;
    logic [4:0]  req1_shamt;
    logic [31:0] req1_a;
    logic [31:0] req1_b;

    logic [4:0]  alu_opcode;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        alu_ne;
    logic        alu_lt;
    logic        alu_ovf;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_ne;
    logic        rsp_lt;
    logic        rsp_ovf;

    logic        busy;

    modport slave (
        input  req0_valid, req0_opcode, req0_shamt, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_opcode, req1_shamt, req1_a, req1_b,
        output req1_ready,
        output alu_opcode, alu_shamt, alu_a, alu_b,
        input  alu_result, alu_ne, alu_lt, alu_ovf,
        output rsp_valid, rsp_id, rsp_result, rsp_ne, rsp_lt, rsp_ovf,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_opcode, req0_shamt, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_opcode, req1_shamt, req1_a, req1_b,
        input  req1_ready,
        input  alu_opcode, alu_shamt, alu_a, alu_b,
        output alu_result, alu_ne, alu_lt, alu_ovf,
        input  rsp_valid, rsp_id, rsp_result, rsp_ne, rsp_lt, rsp_ovf,
        output rsp_ready,
        input  busy
    );
endinterface

// File: rtl/alu_share_arb.sv
// -----------------------------------------------------------------------------
// alu_share_arb
// Two-requester arbiter/sequencer for the single shared 32-bit ALU.
// One transaction in flight: IDLE (grant) -> EXEC (ALU evaluates registered
// operands) -> RESP (tagged result held until rsp_ready).
// Parameters:
//   FIXED_PRIO : 0 = round-robin between requesters, 1 = requester 0 wins ties
// Optional feature macro:
//   ALU_ARB_FLAGS_EN : when defined, alu_ne/alu_lt/alu_ovf are captured and
//                      returned on rsp_ne/rsp_lt/rsp_ovf; otherwise those
//                      outputs are tied low and the flag inputs are ignored.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : alu_share_arb_if.slave (requests, ALU drive/return, response, busy)
// -----------------------------------------------------------------------------
module alu_share_arb #(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    alu_share_arb_if.slave       bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam bit FIXED_PRIO_C = (FIXED_PRIO != 0);

    state_t      state_r;
    logic        ptr_r;          // requester that wins the next tie (round-robin)
    logic        grant0_s;
    logic        grant1_s;
    logic [4:0]  alu_opcode_r;
    logic [4:0]  alu_shamt_r;
    logic [31:0] alu_a_r;
    logic [31:0] alu_b_r;
    logic        rsp_valid_r;
    logic        rsp_id_r;
    logic [31:0] rsp_result_r;
    logic        busy_r;

    // Grant decode: only in IDLE and out of reset; follows the live valids so a
    // requester withdrawing valid is never granted.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if ((state_r == ST_IDLE) && reset_n) begin
            if (bus.req0_valid && bus.req1_valid) begin
                if (FIXED_PRIO_C || (ptr_r == 1'b0)) begin
                    grant0_s = 1'b1;
                end else begin
                    grant1_s = 1'b1;
                end
            end else if (bus.req0_valid) begin
                grant0_s = 1'b1;
            end else if (bus.req1_valid) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Sequencer: accept/latch operands, capture the ALU result, hold the response.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            ptr_r        <= 1'b0;
            alu_opcode_r <= 5'd0;
            alu_shamt_r  <= 5'd0;
            alu_a_r      <= 32'd0;
            alu_b_r      <= 32'd0;
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= 1'b0;
            rsp_result_r <= 32'd0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant0_s || grant1_s) begin
                        alu_opcode_r <= grant0_s ? bus.req0_opcode : bus.req1_opcode;
                        alu_shamt_r  <= grant0_s ? bus.req0_shamt  : bus.req1_shamt;
                        alu_a_r      <= grant0_s ? bus.req0_a      : bus.req1_a;
                        alu_b_r      <= grant0_s ? bus.req0_b      : bus.req1_b;
                        rsp_id_r     <= grant1_s;
                        // Hand the tie to the requester that was not just served.
                        ptr_r        <= grant0_s;
                        busy_r       <= 1'b1;
                        state_r      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_result_r <= bus.alu_result;
                    rsp_valid_r  <= 1'b1;
                    state_r      <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready = grant0_s;
    assign bus.req1_ready = grant1_s;
    assign bus.alu_opcode = alu_opcode_r;
    assign bus.alu_shamt  = alu_shamt_r;
    assign bus.alu_a      = alu_a_r;
    assign bus.alu_b      = alu_b_r;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_id     = rsp_id_r;
    assign bus.rsp_result = rsp_result_r;
    assign bus.busy       = busy_r;

`ifdef ALU_ARB_FLAGS_EN
    logic rsp_ne_r;
    logic rsp_lt_r;
    logic rsp_ovf_r;

    // Flag capture alongside the result; meaning of each flag is the ALU's.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_ne_r  <= 1'b0;
            rsp_lt_r  <= 1'b0;
            rsp_ovf_r <= 1'b0;
        end else if (state_r == ST_EXEC) begin
            rsp_ne_r  <= bus.alu_ne;
            rsp_lt_r  <= bus.alu_lt;
            rsp_ovf_r <= bus.alu_ovf;
        end
    end

    assign bus.rsp_ne  = rsp_ne_r;
    assign bus.rsp_lt  = rsp_lt_r;
    assign bus.rsp_ovf = rsp_ovf_r;
`else
    logic unused_flags_s;
    assign unused_flags_s = bus.alu_ne ^ bus.alu_lt ^ bus.alu_ovf;
    assign bus.rsp_ne  = 1'b0;
    assign bus.rsp_lt  = 1'b0;
    assign bus.rsp_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arb
// Bench for alu_share_arb. dut0 is round-robin, dut1 is fixed priority; both
// see identical requester stimulus. The bench also plays the ALU.
// -----------------------------------------------------------------------------
module tb_alu_share_arb;

    typedef struct {
        logic        id;
        logic [4:0]  op;
        logic [4:0]  sh;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ne;
        logic        lt;
        logic        ovf;
    } vec_t;

`ifdef ALU_ARB_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic clock;
    logic reset_n;
    int   total;
    int   bad;
    int   mon1_cnt;
    bit   mon1_en;
    vec_t sb[$];
    vec_t vecs[8];

    alu_share_arb_if ifc0();
    alu_share_arb_if ifc1();

    alu_share_arb #(.FIXED_PRIO(0)) dut0 (.clock(clock), .reset_n(reset_n), .bus(ifc0.slave));
    alu_share_arb #(.FIXED_PRIO(1)) dut1 (.clock(clock), .reset_n(reset_n), .bus(ifc1.slave));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural ALU: {ne, lt, ovf, result}
    function automatic logic [34:0] alu_model(input logic [4:0] op, input logic [4:0] sh,
                                              input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        ovf;
        r   = 32'h0;
        ovf = 1'b0;
        case (op)
            5'd0: begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
            5'd1: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
            5'd2: r = a & b;
            5'd3: r = a | b;
            5'd4: r = a << sh;
            5'd5: r = $signed(a) >>> sh;
            default: r = 32'h0;
        endcase
        return {a != b, $signed(a) < $signed(b), ovf, r};
    endfunction

    assign {ifc0.alu_ne, ifc0.alu_lt, ifc0.alu_ovf, ifc0.alu_result} =
        alu_model(ifc0.alu_opcode, ifc0.alu_shamt, ifc0.alu_a, ifc0.alu_b);
    assign {ifc1.alu_ne, ifc1.alu_lt, ifc1.alu_ovf, ifc1.alu_result} =
        alu_model(ifc1.alu_opcode, ifc1.alu_shamt, ifc1.alu_a, ifc1.alu_b);

    assign ifc1.req0_valid  = ifc0.req0_valid;
    assign ifc1.req0_opcode = ifc0.req0_opcode;
    assign ifc1.req0_shamt  = ifc0.req0_shamt;
    assign ifc1.req0_a      = ifc0.req0_a;
    assign ifc1.req0_b      = ifc0.req0_b;
    assign ifc1.req1_valid  = ifc0.req1_valid;
    assign ifc1.req1_opcode = ifc0.req1_opcode;
    assign ifc1.req1_shamt  = ifc0.req1_shamt;
    assign ifc1.req1_a      = ifc0.req1_a;
    assign ifc1.req1_b      = ifc0.req1_b;
    assign ifc1.rsp_ready   = ifc0.rsp_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_req(input vec_t v, input logic valid);
        if (v.id == 1'b0) begin
            ifc0.req0_opcode = v.op; ifc0.req0_shamt = v.sh;
            ifc0.req0_a = v.a; ifc0.req0_b = v.b; ifc0.req0_valid = valid;
        end else begin
            ifc0.req1_opcode = v.op; ifc0.req1_shamt = v.sh;
            ifc0.req1_a = v.a; ifc0.req1_b = v.b; ifc0.req1_valid = valid;
        end
    endtask

    // Present a request (entered just after a rising edge), wait for the grant,
    // push the expected response, then withdraw valid.
    task automatic issue(input vec_t v);
        bit done;
        done = 1'b0;
        drive_req(v, 1'b1);
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clock);
            if ((v.id == 1'b0 && ifc0.req0_ready) || (v.id == 1'b1 && ifc0.req1_ready)) begin
                sb.push_back(v);
                done = 1'b1;
            end
        end
        @(posedge clock); #1;
        drive_req(v, 1'b0);
        if (!done) begin
            total++; bad++;
            $display("FAIL grant_timeout: id=%0d never granted", v.id);
        end
    endtask

    task automatic wait_drain(input int budget);
        for (int c = 0; c < budget && sb.size() != 0; c++) @(negedge clock);
        check("drain", sb.size(), 0);
        @(posedge clock); #1;
    endtask

    // Response monitor for the round-robin instance, scoreboard-driven.
    always @(negedge clock) begin
        vec_t e;
        if (ifc0.rsp_valid && ifc0.rsp_ready) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_rsp: id=%0d result=%h", ifc0.rsp_id, ifc0.rsp_result);
            end else begin
                e = sb.pop_front();
                check("rsp_id", ifc0.rsp_id, e.id);
                check("rsp_result", ifc0.rsp_result, e.res);
                check("rsp_ne", ifc0.rsp_ne, FLAGS_EN ? e.ne : 1'b0);
                check("rsp_lt", ifc0.rsp_lt, FLAGS_EN ? e.lt : 1'b0);
                check("rsp_ovf", ifc0.rsp_ovf, FLAGS_EN ? e.ovf : 1'b0);
            end
        end
    end

    // Fixed-priority instance: while both requesters are held, requester 0 always wins.
    always @(negedge clock) begin
        if (mon1_en && ifc1.rsp_valid && ifc1.rsp_ready) begin
            check("fixed_rsp_id", ifc1.rsp_id, 1'b0);
            mon1_cnt++;
        end
    end

    initial begin
        vec_t v;
        int   acc;
        total = 0; bad = 0; mon1_cnt = 0; mon1_en = 1'b0;
        vecs[0] = '{1'b0, 5'd0, 5'd0,  32'd5,         32'd7,         32'd12,        1'b1, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 5'd1, 5'd0,  32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 5'd2, 5'd0,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 5'd3, 5'd0,  32'h1200_0000, 32'h0000_0034, 32'h1200_0034, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 5'd5, 5'd4,  32'h8000_0000, 32'd0,         32'hF800_0000, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 5'd4, 5'd31, 32'd3,         32'd0,         32'h8000_0000, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 5'd0, 5'd0,  32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 5'd1, 5'd0,  32'd9,         32'd9,         32'd0,         1'b0, 1'b0, 1'b0};

        reset_n = 1'b0;
        ifc0.req0_valid = 1'b0; ifc0.req0_opcode = 5'd0; ifc0.req0_shamt = 5'd0;
        ifc0.req0_a = 32'd0; ifc0.req0_b = 32'd0;
        ifc0.req1_valid = 1'b0; ifc0.req1_opcode = 5'd0; ifc0.req1_shamt = 5'd0;
        ifc0.req1_a = 32'd0; ifc0.req1_b = 32'd0;
        ifc0.rsp_ready = 1'b1;

        // Reset state, with both valids raised to show ready stays low.
        repeat (2) @(negedge clock);
        ifc0.req0_valid = 1'b1; ifc0.req1_valid = 1'b1;
        #1;
        check("rst_ready0", ifc0.req0_ready, 1'b0);
        check("rst_ready1", ifc0.req1_ready, 1'b0);
        check("rst_rsp_valid", ifc0.rsp_valid, 1'b0);
        check("rst_busy", ifc0.busy, 1'b0);
        check("rst_alu_a", ifc0.alu_a, 32'd0);
        check("rst_alu_op", ifc0.alu_opcode, 5'd0);
        check("rst_rsp_result", ifc0.rsp_result, 32'd0);
        check("rst_rsp_id", ifc0.rsp_id, 1'b0);
        ifc0.req0_valid = 1'b0; ifc0.req1_valid = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Single add with latency checks: accept at N, EXEC, rsp_valid from N+1.
        drive_req(vecs[0], 1'b1);
        @(negedge clock);
        check("add_ready0", ifc0.req0_ready, 1'b1);
        sb.push_back(vecs[0]);
        @(posedge clock); #1;
        drive_req(vecs[0], 1'b0);
        @(negedge clock);
        check("exec_rsp_valid", ifc0.rsp_valid, 1'b0);
        check("exec_busy", ifc0.busy, 1'b1);
        check("exec_ready0", ifc0.req0_ready, 1'b0);
        @(negedge clock);
        check("resp_rsp_valid", ifc0.rsp_valid, 1'b1);
        @(posedge clock); #1;
        wait_drain(10);

        // Vector table, each requester alone.
        for (int i = 0; i < 8; i++) issue(vecs[i]);
        wait_drain(20);

        // Backpressure: sll held in RESP for 5 cycles with req0 waiting.
        ifc0.rsp_ready = 1'b0;
        v = '{1'b1, 5'd4, 5'd4, 32'd1, 32'd0, 32'h10, 1'b1, 1'b0, 1'b0};
        issue(v);
        v = '{1'b0, 5'd0, 5'd0, 32'd2, 32'd3, 32'd5, 1'b1, 1'b1, 1'b0};
        drive_req(v, 1'b1);
        @(negedge clock);
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            check("bp_rsp_valid", ifc0.rsp_valid, 1'b1);
            check("bp_rsp_result", ifc0.rsp_result, 32'h10);
            check("bp_rsp_id", ifc0.rsp_id, 1'b1);
            check("bp_ready0", ifc0.req0_ready, 1'b0);
            check("bp_ready1", ifc0.req1_ready, 1'b0);
        end
        @(posedge clock); #1;
        ifc0.rsp_ready = 1'b1;
        @(negedge clock);
        check("bp_release_ready0", ifc0.req0_ready, 1'b0);
        @(negedge clock);
        check("bp_idle_ready0", ifc0.req0_ready, 1'b1);
        sb.push_back(v);
        @(posedge clock); #1;
        drive_req(v, 1'b0);
        wait_drain(10);

        // Round-robin vs fixed priority with both requesters held.
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        mon1_cnt = 0; mon1_en = 1'b1;
        v = '{1'b0, 5'd0, 5'd0, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0};
        drive_req(v, 1'b1);
        sb.push_back(v);
        v = '{1'b1, 5'd0, 5'd0, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0, 1'b0};
        drive_req(v, 1'b1);
        sb.push_back(v);
        sb.push_back(sb[0]);
        sb.push_back(v);
        acc = 0;
        for (int c = 0; c < 40 && acc < 4; c++) begin
            @(negedge clock);
            if (ifc0.req0_ready || ifc0.req1_ready) acc++;
        end
        @(posedge clock); #1;
        ifc0.req0_valid = 1'b0; ifc0.req1_valid = 1'b0;
        check("rr_accepts", acc, 32'd4);
        wait_drain(20);
        check("fixed_rsp_count", mon1_cnt, 32'd4);
        mon1_en = 1'b0;

        // Reset mid-EXEC: transaction from requester 0 (pointer moves to 1) is dropped.
        v = '{1'b0, 5'd0, 5'd0, 32'd6, 32'd1, 32'd7, 1'b1, 1'b0, 1'b0};
        drive_req(v, 1'b1);
        @(negedge clock);
        check("mid_ready0", ifc0.req0_ready, 1'b1);
        @(posedge clock); #1;
        drive_req(v, 1'b0);
        check("mid_busy_before", ifc0.busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", ifc0.rsp_valid, 1'b0);
        check("mid_rst_busy", ifc0.busy, 1'b0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            check("post_rst_no_rsp", ifc0.rsp_valid, 1'b0);
        end
        @(posedge clock); #1;
        ifc0.req1_opcode = 5'd0; ifc0.req1_a = 32'd1; ifc0.req1_b = 32'd1;
        ifc0.req1_valid = 1'b1;
        drive_req(v, 1'b1);
        @(negedge clock);
        check("post_rst_ready0", ifc0.req0_ready, 1'b1);
        check("post_rst_ready1", ifc0.req1_ready, 1'b0);
        sb.push_back(v);
        @(posedge clock); #1;
        ifc0.req0_valid = 1'b0; ifc0.req1_valid = 1'b0;
        wait_drain(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-requester arbiter and sequencer for the single shared 32-bit ALU. It accepts operations from two independent requesters over valid/ready handshakes and grants the ALU to one of them, round-robin or fixed priority. It drives registered operands into the ALU, captures the combinational result and flags one cycle later, and returns them on a single tagged response channel. It sits between the execute stage (requester 0), the auxiliary sequencer (requester 1) and the ALU instance.

## Interface
- FIXED_PRIO, 0: 0 = round-robin; 1 = requester 0 always wins ties.
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_opcode / req1_opcode  in  5  ALU opcode: 00000 add, 00001 sub, 00010 and, 00011 or, 00100 sll, 00101 sra.
- req0_shamt / req1_shamt  in  5  shift amount.
- req0_a, req0_b / req1_a, req1_b  in  32  operands.
- alu_opcode, alu_shamt  out  5  to ALU.
- alu_a, alu_b  out  32  to ALU.
- alu_result  in  32  from ALU.
- alu_ne, alu_lt, alu_ovf  in  1  ALU isNotEqual / isLessThan / overflow.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester that issued the response.
- rsp_result  out  32  captured result.
- rsp_ne, rsp_lt, rsp_ovf  out  1  captured flags; present only with ALU_ARB_FLAGS_EN.
- busy  out  1  state != IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready = 1 only for the granted requester, combinational from the valids and the priority pointer.
  - On an edge with a granted valid: latch opcode, shamt, a and b into the ALU-drive registers; latch the id; go to EXEC.
- EXEC: the ALU sees stable registered inputs. On the next edge, capture alu_result and the flags into the response registers and go to RESP.
- RESP:
  - rsp_valid = 1.
  - On an edge with rsp_ready = 1, go to IDLE.
  - rsp_* outputs hold stable while rsp_ready = 0.
- Both ready outputs are 0 in EXEC and RESP; only one transaction is in flight.
- Arbitration:
  - Only one valid: grant it.
  - Both valid, FIXED_PRIO = 1: grant requester 0.
  - Both valid, FIXED_PRIO = 0: grant the pointer holder. After each grant, the pointer moves to the other requester.
  - The pointer updates only on an accepted grant.
- ALU-drive registers hold their last values outside a new accept; no toggling while idle.
- Requesters must hold their fields stable while valid = 1 and ready = 0. A requester may drop valid before it is granted.
- Flags are captured unconditionally. Their meaning follows the ALU: ne and lt are valid for sub, ovf for add and sub.

## Timing
- Reset (async assert, sync release) puts every register in its reset state:
  - state = IDLE, pointer = requester 0.
  - alu_opcode, alu_shamt, alu_a, alu_b = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_result = 0, all rsp flags = 0, busy = 0.
  - Both ready outputs = 0 while reset_n = 0.
- Latency: request accepted at edge N; rsp_valid is high from edge N+1.
- Best-case throughput: one operation per 3 cycles (IDLE, EXEC, RESP with rsp_ready held at 1).
- Reset mid-EXEC or mid-RESP: the transaction is dropped, no response is produced, and the pointer returns to requester 0.
- A request whose valid drops in the same cycle as its grant is not accepted; ready is computed from the current valid.
- No combinational path from rsp_ready to either reqN_ready. A new accept happens no earlier than the cycle after RESP exits.

## Configuration
- ALU_ARB_FLAGS_EN defined:
  - alu_ne, alu_lt and alu_ovf are registered in EXEC.
  - They are presented on rsp_ne, rsp_lt and rsp_ovf with the result.
- ALU_ARB_FLAGS_EN undefined:
  - No flag registers.
  - rsp_ne, rsp_lt and rsp_ovf are tied to 0.
  - The alu_ne, alu_lt and alu_ovf inputs are ignored.

## Test plan
- Single add: req0 with opcode 00000, a = 5, b = 7 -> req0_ready = 1 that cycle; two edges later rsp_valid = 1, rsp_id = 0, rsp_result = 12.
- Simultaneous requests: req0 and req1 both valid and held, FIXED_PRIO = 0, rsp_ready = 1 -> grants alternate 0, 1, 0, 1 (rsp_id sequence). With FIXED_PRIO = 1 -> requester 0 always wins while valid.
- Overflow and flags (ALU_ARB_FLAGS_EN): sub with a = 32'h80000000, b = 1 -> rsp_result = 32'h7FFFFFFF, rsp_ovf = 1, rsp_lt = 1, rsp_ne = 1. Without the macro, all rsp flags read 0.
- Backpressure: rsp_ready held 0 for 5 cycles after a sll with a = 1, shamt = 4 -> rsp_valid and rsp_result = 32'h10 stay stable and both ready outputs stay 0. Release -> IDLE next cycle.
- Reset mid-operation: assert reset_n = 0 while in EXEC -> asynchronously rsp_valid = 0 and busy = 0. No response after release, and the next dual request grants requester 0.
